// File: rtl/mcu_pkg.sv
// Shared constants and types for the MCU SPI link and the targets hanging off it.
package mcu_pkg;

    localparam int TGT_SYS = 0;
    localparam int TGT_HID = 1;
    localparam int TGT_SDC = 2;

    localparam logic [7:0] IDLE_REPLY = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TARGET,
        ST_COMMAND,
        ST_PAYLOAD
    } link_state_e;

    // MSB-first shift: drop the top bit, append the new one at the bottom.
    function automatic logic [7:0] shift_in(input logic [7:0] value, input logic bit_in);
        return {value[6:0], bit_in};
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous SPI line, with single-clk
// rise and fall pulses derived from the synchronized level.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
    end

    // The reset value sets the level that is assumed before reset is released,
    // so a line already sitting at that level produces no edge afterwards.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/mcu_spi_link.sv
// SPI mode-0 target for the IO MCU link: deframes target/command/payload bytes
// into per-target strobes and shifts each target's reply byte back on MISO.
module mcu_spi_link
    import mcu_pkg::*;
#(
    parameter int NUM_TARGETS = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     spi_csn,
    input  logic                     spi_sclk,
    input  logic                     spi_mosi,
    output logic                     spi_miso,
    output logic [NUM_TARGETS-1:0]   tgt_strobe,
    output logic                     tgt_start,
    output logic [7:0]               tgt_data,
    input  logic [8*NUM_TARGETS-1:0] tgt_reply,
    output logic                     link_busy
);

    logic csn_rise;
    logic csn_fall;
    logic sclk_rise;
    logic sclk_fall;

    // CSn starts low after reset so an already-open frame cannot look like a fresh CSn fall.
    spi_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_csn_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (spi_csn),
        .rise    (csn_rise),
        .fall    (csn_fall)
    );

    spi_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sclk_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (spi_sclk),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_d;
    logic                   mosi_s;

    always_comb begin
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= mosi_sync_d;
        end
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    link_state_e            state_q,   state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [6:0]             rx_shift_q, rx_shift_d;
    logic [7:0]             tgt_id_q,  tgt_id_d;
    logic [7:0]             tx_shift_q, tx_shift_d;
    logic                   load_pend_q, load_pend_d;
    logic [7:0]             tgt_data_q, tgt_data_d;
    logic [NUM_TARGETS-1:0] strobe_q,  strobe_d;
    logic                   start_q,   start_d;
    logic                   busy_q,    busy_d;

    logic [NUM_TARGETS-1:0] sel_onehot;
    logic [7:0]             reply_sel;
    logic                   tgt_valid;
    logic [7:0]             rx_byte;

    // Out-of-range ids decode to no target: no strobe and an all-zero reply.
    always_comb begin
        sel_onehot = '0;
        reply_sel  = IDLE_REPLY;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            if (tgt_id_q == 8'(i)) begin
                sel_onehot[i] = 1'b1;
                reply_sel     = tgt_reply[8*i +: 8];
            end
        end
    end

    assign tgt_valid = |sel_onehot;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tgt_id_d    = tgt_id_q;
        tx_shift_d  = tx_shift_q;
        load_pend_d = load_pend_q;
        tgt_data_d  = tgt_data_q;
        strobe_d    = '0;
        start_d     = 1'b0;
        busy_d      = busy_q;
        rx_byte     = shift_in({1'b0, rx_shift_q}, mosi_s);

        if (csn_rise) begin
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            load_pend_d = 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (csn_fall) begin
                state_d     = ST_TARGET;
                bit_cnt_d   = 3'd0;
                rx_shift_d  = 7'd0;
                tx_shift_d  = IDLE_REPLY;
                load_pend_d = 1'b0;
                busy_d      = 1'b1;
            end
        end else begin
            if (sclk_rise) begin
                rx_shift_d = rx_byte[6:0];
                bit_cnt_d  = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    load_pend_d = 1'b1;
                    unique case (state_q)
                        ST_TARGET: begin
                            tgt_id_d = rx_byte;
                            state_d  = ST_COMMAND;
                        end
                        ST_COMMAND: begin
                            state_d = ST_PAYLOAD;
                            if (tgt_valid) begin
                                tgt_data_d = rx_byte;
                                strobe_d   = sel_onehot;
                                start_d    = 1'b1;
                            end
                        end
                        ST_PAYLOAD: begin
                            if (tgt_valid) begin
                                tgt_data_d = rx_byte;
                                strobe_d   = sel_onehot;
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end
            // The reply is only fetched once the command byte is in, so byte0/1 clock out zeros.
            if (sclk_fall) begin
                if (load_pend_q) begin
                    tx_shift_d  = (state_q == ST_PAYLOAD) ? reply_sel : IDLE_REPLY;
                    load_pend_d = 1'b0;
                end else begin
                    tx_shift_d = shift_in(tx_shift_q, 1'b0);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 7'd0;
            tgt_id_q    <= 8'h00;
            tx_shift_q  <= IDLE_REPLY;
            load_pend_q <= 1'b0;
            tgt_data_q  <= 8'h00;
            strobe_q    <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tgt_id_q    <= tgt_id_d;
            tx_shift_q  <= tx_shift_d;
            load_pend_q <= load_pend_d;
            tgt_data_q  <= tgt_data_d;
            strobe_q    <= strobe_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
        end
    end

    assign spi_miso   = tx_shift_q[7];
    assign tgt_strobe = strobe_q;
    assign tgt_start  = start_q;
    assign tgt_data   = tgt_data_q;
    assign link_busy  = busy_q;

endmodule

// File: tb/tb_mcu_spi_link.sv
// Scoreboard bench for mcu_spi_link: an SPI master task drives frames, a target
// emulator answers strobes, and a monitor pops expected strobes as they appear.
module tb_mcu_spi_link;
    import mcu_pkg::*;

    localparam int NUM_TARGETS = 3;
    localparam int SYNC_STAGES = 2;

    typedef struct packed {
        logic [7:0] tgt;
        logic       start;
        logic [7:0] data;
    } strobe_t;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     spi_csn;
    logic                     spi_sclk;
    logic                     spi_mosi;
    logic                     spi_miso;
    logic [NUM_TARGETS-1:0]   tgt_strobe;
    logic                     tgt_start;
    logic [7:0]               tgt_data;
    logic [8*NUM_TARGETS-1:0] tgt_reply;
    logic                     link_busy;

    int tests_run    = 0;
    int tests_failed = 0;

    strobe_t    exp_q[$];
    logic [7:0] reply_plan[$];
    logic [7:0] frame_buf[8];
    logic [7:0] plan_arr[8];

    mcu_spi_link #(
        .NUM_TARGETS (NUM_TARGETS),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .spi_csn    (spi_csn),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .tgt_strobe (tgt_strobe),
        .tgt_start  (tgt_start),
        .tgt_data   (tgt_data),
        .tgt_reply  (tgt_reply),
        .link_busy  (link_busy)
    );

    initial forever #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    initial begin
        strobe_t                e;
        logic [NUM_TARGETS-1:0] exp_vec;
        forever begin
            @(negedge clk);
            if (tgt_strobe != '0) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_strobe", 32'(tgt_strobe), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    for (int i = 0; i < NUM_TARGETS; i++) exp_vec[i] = (e.tgt == 8'(i));
                    check_output("strobe_vec", 32'(tgt_strobe), 32'(exp_vec));
                    check_output("strobe_start", 32'(tgt_start), 32'(e.start));
                    check_output("strobe_data", 32'(tgt_data), 32'(e.data));
                end
            end
        end
    end

    // Target emulator: after each strobe the addressed target posts its next reply.
    initial begin
        forever begin
            @(negedge clk);
            for (int t = 0; t < NUM_TARGETS; t++) begin
                if (tgt_strobe[t] && reply_plan.size() > 0) begin
                    tgt_reply[8*t +: 8] = reply_plan.pop_front();
                end
            end
        end
    end

    task automatic send_bits(input logic [7:0] val, input int nb, input bit cs_on_last, output logic [7:0] miso_byte);
        miso_byte = 8'h00;
        for (int b = 0; b < nb; b++) begin
            spi_mosi = val[7-b];
            repeat (4) @(negedge clk);
            miso_byte = {miso_byte[6:0], spi_miso};
            if (cs_on_last && b == nb - 1) spi_csn = 1'b1;
            spi_sclk = 1'b1;
            repeat (4) @(negedge clk);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic drain_check();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        check_output("strobes_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Runs one frame from frame_buf; last_bits < 8 truncates the final byte, and
    // coincide raises CSn together with the final byte's 8th SCLK rise.
    task automatic run_frame(input int nbytes, input int last_bits, input bit coincide);
        logic [7:0] got;
        logic [7:0] expm;
        bit         valid;
        int         complete;
        int         nb;
        bit         last;
        valid    = frame_buf[0] < 8'(NUM_TARGETS);
        complete = (last_bits == 8 && !coincide) ? nbytes : nbytes - 1;
        reply_plan.delete();
        if (valid) begin
            for (int k = 1; k < complete; k++) begin
                exp_q.push_back('{tgt: frame_buf[0], start: (k == 1), data: frame_buf[k]});
                reply_plan.push_back(plan_arr[k-1]);
            end
        end
        for (int t = 0; t < NUM_TARGETS; t++) tgt_reply[8*t +: 8] = 8'($urandom);
        spi_csn = 1'b0;
        repeat (6) @(negedge clk);
        check_output("busy_after_csn_fall", 32'(link_busy), 32'd1);
        for (int k = 0; k < nbytes; k++) begin
            last = (k == nbytes - 1);
            nb   = last ? last_bits : 8;
            send_bits(frame_buf[k], nb, coincide && last, got);
            if (nb == 8 && !(coincide && last)) begin
                expm = (!valid || k < 2) ? IDLE_REPLY : plan_arr[k-2];
                check_output($sformatf("miso_byte%0d", k), 32'(got), 32'(expm));
            end
        end
        repeat (4) @(negedge clk);
        spi_csn = 1'b1;
        repeat (6) @(negedge clk);
        check_output("busy_after_csn_rise", 32'(link_busy), 32'd0);
        drain_check();
    endtask

    initial begin
        logic [7:0] got;
        int         n;
        reset_n   = 1'b0;
        spi_csn   = 1'b1;
        spi_sclk  = 1'b0;
        spi_mosi  = 1'b0;
        tgt_reply = '0;
        repeat (4) @(negedge clk);
        check_output("rst_strobe", 32'(tgt_strobe), 32'd0);
        check_output("rst_start", 32'(tgt_start), 32'd0);
        check_output("rst_data", 32'(tgt_data), 32'd0);
        check_output("rst_miso", 32'(spi_miso), 32'd0);
        check_output("rst_busy", 32'(link_busy), 32'd0);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);

        // Basic HID frame: command strobe then one payload strobe.
        frame_buf[0] = 8'(TGT_HID); frame_buf[1] = 8'h01; frame_buf[2] = 8'h93;
        plan_arr[0] = 8'h11; plan_arr[1] = 8'h22;
        run_frame(3, 8, 1'b0);

        // Reply bytes appear on MISO one byte after the strobe that requested them.
        frame_buf[0] = 8'h01; frame_buf[1] = 8'h00; frame_buf[2] = 8'h00; frame_buf[3] = 8'h00;
        plan_arr[0] = 8'h5C; plan_arr[1] = 8'h42; plan_arr[2] = 8'h77;
        run_frame(4, 8, 1'b0);

        // Invalid target id.
        frame_buf[0] = 8'h07; frame_buf[1] = 8'h02; frame_buf[2] = 8'hAA;
        run_frame(3, 8, 1'b0);

        // Abort after 5 bits of byte2, then a clean frame to target 0.
        frame_buf[0] = 8'h01; frame_buf[1] = 8'h22; frame_buf[2] = 8'h33;
        plan_arr[0] = 8'hA5;
        run_frame(3, 5, 1'b0);
        frame_buf[0] = 8'h00; frame_buf[1] = 8'h05;
        plan_arr[0] = 8'h3C;
        run_frame(2, 8, 1'b0);

        // CSn rise coincides with the 8th SCLK rise of byte1.
        frame_buf[0] = 8'h02; frame_buf[1] = 8'h11;
        run_frame(2, 8, 1'b1);

        // Reset pulse mid byte1; later SCLK activity without a new CSn fall is ignored.
        reply_plan.delete();
        spi_csn = 1'b0;
        repeat (6) @(negedge clk);
        send_bits(8'h01, 8, 1'b0, got);
        send_bits(8'hC3, 3, 1'b0, got);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_output("midrst_strobe", 32'(tgt_strobe), 32'd0);
        check_output("midrst_start", 32'(tgt_start), 32'd0);
        check_output("midrst_data", 32'(tgt_data), 32'd0);
        check_output("midrst_miso", 32'(spi_miso), 32'd0);
        check_output("midrst_busy", 32'(link_busy), 32'd0);
        send_bits(8'hFF, 8, 1'b0, got);
        send_bits(8'h5A, 8, 1'b0, got);
        check_output("midrst_miso_byte", 32'(got), 32'd0);
        check_output("midrst_busy_hold", 32'(link_busy), 32'd0);
        repeat (4) @(negedge clk);
        spi_csn = 1'b1;
        repeat (6) @(negedge clk);
        drain_check();
        check_output("midrst_data_hold", 32'(tgt_data), 32'd0);

        // Random frames, including occasional invalid ids.
        for (int f = 0; f < 8; f++) begin
            n = $urandom_range(2, 6);
            frame_buf[0] = 8'($urandom_range(0, 4));
            for (int k = 1; k < n; k++) frame_buf[k] = 8'($urandom);
            for (int k = 0; k < 8; k++) plan_arr[k] = 8'($urandom);
            run_frame(n, 8, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
